// File: rtl/input_config_loader.sv
// Loads the input-mapping tables from a byte stream into a shadow bank and commits them atomically.
// Optional build macro INPUT_CONFIG_LOADER_CHECKSUM_EN appends a mod-256 zero-sum checksum byte to the record.
module input_config_loader #(
  parameter int NUM_ROWS       = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         data_valid,
  input  logic [7:0]   data_in,
  output logic         data_ready,
  output logic [255:0] input_s_config,
  output logic [7:0]   input_b_config,
  output logic [7:0]   input_ba_config,
  output logic [7:0]   input_acl_config,
  output logic [3:0]   grounded_port_config,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int ROW_BYTES = NUM_ROWS * 4;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
  localparam int REC_LEN = ROW_BYTES + 5;
`else
  localparam int REC_LEN = ROW_BYTES + 4;
`endif
  localparam int CNT_W = $clog2(ROW_BYTES + 5);
  localparam int RW    = $clog2(ROW_BYTES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 2);

  localparam logic [CNT_W-1:0] IDX_B    = CNT_W'(ROW_BYTES);
  localparam logic [CNT_W-1:0] IDX_BA   = CNT_W'(ROW_BYTES + 1);
  localparam logic [CNT_W-1:0] IDX_ACL  = CNT_W'(ROW_BYTES + 2);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(REC_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_FAIL
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] byte_cnt;
  logic [TO_W-1:0]  timeout_cnt;
  logic [7:0]       shadow_s [ROW_BYTES];
  logic [7:0]       shadow_b;
  logic [7:0]       shadow_ba;
  logic [7:0]       shadow_acl;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
  localparam logic [CNT_W-1:0] IDX_GND = CNT_W'(ROW_BYTES + 3);
  logic [3:0]       shadow_gnd;
  logic             gnd_bad_q;
  logic [7:0]       sum_q;
`endif

  logic handshake;
  logic last_hs;
  logic gnd_bad_now;
  logic timeout_hit;
  logic rec_ok;

  assign handshake   = data_valid && (state == S_LOAD);
  assign last_hs     = handshake && (byte_cnt == IDX_LAST);
  assign gnd_bad_now = (data_in[7:4] != 4'h0) || ({28'd0, data_in[3:0]} > 32'(NUM_ROWS));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !handshake && (timeout_cnt == TO_LIMIT);

`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
  // Last byte is the checksum; the grounded byte was judged when it arrived.
  assign rec_ok = !gnd_bad_q && (8'(sum_q + data_in) == 8'h00);
`else
  assign rec_ok = !gnd_bad_now;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_LOAD;
      end
      S_LOAD: begin
        data_ready = 1'b1;
        if (last_hs)          state_next = rec_ok ? S_COMMIT : S_FAIL;
        else if (timeout_hit) state_next = S_FAIL;
      end
      S_COMMIT: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_FAIL:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt             <= '0;
      timeout_cnt          <= '0;
      for (int i = 0; i < ROW_BYTES; i++) shadow_s[i] <= 8'h7F;
      shadow_b             <= 8'h7F;
      shadow_ba            <= 8'h7F;
      shadow_acl           <= 8'h7F;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
      shadow_gnd           <= 4'h0;
      gnd_bad_q            <= 1'b0;
      sum_q                <= 8'h00;
`endif
      input_s_config       <= {8{32'h7F7F_7F7F}};
      input_b_config       <= 8'h7F;
      input_ba_config      <= 8'h7F;
      input_acl_config     <= 8'h7F;
      grounded_port_config <= 4'h0;
      error                <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            byte_cnt    <= '0;
            timeout_cnt <= '0;
            error       <= 1'b0;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
            gnd_bad_q   <= 1'b0;
            sum_q       <= 8'h00;
`endif
          end
        end
        S_LOAD: begin
          if (handshake) begin
            byte_cnt    <= byte_cnt + 1'b1;
            timeout_cnt <= '0;
            if (byte_cnt < IDX_B)         shadow_s[byte_cnt[RW-1:0]] <= data_in;
            else if (byte_cnt == IDX_B)   shadow_b   <= data_in;
            else if (byte_cnt == IDX_BA)  shadow_ba  <= data_in;
            else if (byte_cnt == IDX_ACL) shadow_acl <= data_in;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
            sum_q <= sum_q + data_in;
            if (byte_cnt == IDX_GND) begin
              shadow_gnd <= data_in[3:0];
              gnd_bad_q  <= gnd_bad_now;
            end
`endif
          end else if (timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end

          // Live outputs update on the edge that enters COMMIT so they line up with done.
          if (state_next == S_COMMIT) begin
            for (int r = 0; r < NUM_ROWS; r++)
              input_s_config[32*r +: 32] <= {shadow_s[4*r+3], shadow_s[4*r+2],
                                             shadow_s[4*r+1], shadow_s[4*r]};
            input_b_config   <= shadow_b;
            input_ba_config  <= shadow_ba;
            input_acl_config <= shadow_acl;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
            grounded_port_config <= shadow_gnd;
`else
            grounded_port_config <= data_in[3:0];
`endif
          end
          if (state_next == S_FAIL) error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_input_config_loader.sv
// Directed bench for input_config_loader: commit, grounded-byte errors, timeout, start filtering, reset.
// Honours INPUT_CONFIG_LOADER_CHECKSUM_EN for the record layout and the checksum cases.
module tb_input_config_loader;

  localparam int NUM_ROWS  = 8;
  localparam int TO_CYC    = 16;
  localparam int ROW_BYTES = NUM_ROWS * 4;
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
  localparam int REC_N = ROW_BYTES + 5;
`else
  localparam int REC_N = ROW_BYTES + 4;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         data_valid;
  logic [7:0]   data_in;
  logic         data_ready;
  logic [255:0] input_s_config;
  logic [7:0]   input_b_config;
  logic [7:0]   input_ba_config;
  logic [7:0]   input_acl_config;
  logic [3:0]   grounded_port_config;
  logic         busy;
  logic         done;
  logic         error;

  int checks = 0;
  int errors = 0;

  logic [7:0]   rec [REC_N];
  logic [255:0] exp_s, cur_s;
  logic [7:0]   exp_b, exp_ba, exp_acl, cur_b, cur_ba, cur_acl;
  logic [3:0]   exp_gnd, cur_gnd;

  input_config_loader #(.NUM_ROWS(NUM_ROWS), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .start                (start),
    .data_valid           (data_valid),
    .data_in              (data_in),
    .data_ready           (data_ready),
    .input_s_config       (input_s_config),
    .input_b_config       (input_b_config),
    .input_ba_config      (input_ba_config),
    .input_acl_config     (input_acl_config),
    .grounded_port_config (grounded_port_config),
    .busy                 (busy),
    .done                 (done),
    .error                (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_s"},   input_s_config,       cur_s);
    chk({tag, "_b"},   input_b_config,       {248'd0, cur_b});
    chk({tag, "_ba"},  input_ba_config,      {248'd0, cur_ba});
    chk({tag, "_acl"}, input_acl_config,     {248'd0, cur_acl});
    chk({tag, "_gnd"}, grounded_port_config, {252'd0, cur_gnd});
  endtask

  task automatic set_reset_exp();
    cur_s = {8{32'h7F7F_7F7F}};
    cur_b = 8'h7F; cur_ba = 8'h7F; cur_acl = 8'h7F; cur_gnd = 4'h0;
  endtask

  task automatic accept_exp();
    cur_s = exp_s; cur_b = exp_b; cur_ba = exp_ba; cur_acl = exp_acl; cur_gnd = exp_gnd;
  endtask

  task automatic build_rec(input logic [7:0] base, input logic [7:0] b, input logic [7:0] ba,
                           input logic [7:0] acl, input logic [7:0] gnd);
    logic [7:0] sum;
    for (int i = 0; i < ROW_BYTES; i++) rec[i] = base + 8'(i);
    rec[ROW_BYTES]   = b;
    rec[ROW_BYTES+1] = ba;
    rec[ROW_BYTES+2] = acl;
    rec[ROW_BYTES+3] = gnd;
    sum = 8'h00;
    for (int i = 0; i < ROW_BYTES + 4; i++) sum = sum + rec[i];
`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
    rec[ROW_BYTES+4] = 8'h00 - sum;
`endif
    exp_s = '0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 4; k++)
        exp_s[32*r + 8*k +: 8] = (r < NUM_ROWS) ? rec[4*r+k] : 8'h7F;
    exp_b = b; exp_ba = ba; exp_acl = acl; exp_gnd = gnd[3:0];
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic stream(input int from, input int upto, input int start_a, input int start_b);
    for (int i = from; i < upto; i++) begin
      data_valid = 1'b1;
      data_in    = rec[i];
      start      = (i == start_a) || (i == start_b);
      @(negedge clk);
    end
    data_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic stall(input int n);
    data_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    set_reset_exp();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk_outputs("rst");
    chk("rst_busy",  busy,       1'b0);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_done",  done,       1'b0);
    chk("rst_error", error,      1'b0);

    // Good record
    build_rec(8'h00, 8'h05, 8'h84, 8'h7F, 8'h02);
    do_start();
    chk("t2_busy",  busy,       1'b1);
    chk("t2_ready", data_ready, 1'b1);
    chk_outputs("t2_pre");
    stream(0, REC_N, -1, -1);
    chk("t2_done", done, 1'b1);
    chk("t2_row0", input_s_config[31:0], 32'h0302_0100);
    chk("t2_ba",   input_ba_config, 8'h84);
    chk("t2_gnd",  grounded_port_config, 4'h2);
    accept_exp();
    chk_outputs("t2");
    @(negedge clk);
    chk("t2_busy_lo", busy,       1'b0);
    chk("t2_done_lo", done,       1'b0);
    chk("t2_ready_lo", data_ready, 1'b0);
    chk("t2_error",   error,      1'b0);

    // Bad grounded byte
    build_rec(8'h40, 8'h11, 8'h22, 8'h33, 8'h19);
    do_start();
    stream(0, REC_N, -1, -1);
    chk("t3_done",  done,  1'b0);
    chk("t3_error", error, 1'b1);
    chk_outputs("t3");
    @(negedge clk);
    chk("t3_busy_lo", busy, 1'b0);
    chk("t3_sticky",  error, 1'b1);

    // Grounded = NUM_ROWS is valid; start pulses mid-load and on the last byte are ignored
    build_rec(8'h80, 8'hA1, 8'hB2, 8'hC3, 8'h08);
    do_start();
    chk("t3_clr", error, 1'b0);
    stream(0, REC_N, 5, REC_N - 1);
    chk("t5_done", done, 1'b1);
    accept_exp();
    chk_outputs("t5");
    @(negedge clk);
    chk("t5_busy_lo", busy, 1'b0);
    @(negedge clk);
    chk("t5_no_restart", busy, 1'b0);

    // Grounded = NUM_ROWS+1 is invalid
    build_rec(8'h90, 8'h01, 8'h02, 8'h03, 8'h09);
    do_start();
    stream(0, REC_N, -1, -1);
    chk("t3b_error", error, 1'b1);
    chk("t3b_done",  done,  1'b0);
    chk_outputs("t3b");
    @(negedge clk);

    // Stall one short of the timeout: record still completes
    build_rec(8'hC0, 8'h5A, 8'hA5, 8'h3C, 8'h01);
    do_start();
    stream(0, 10, -1, -1);
    stall(TO_CYC - 1);
    chk("t4_busy_stall", busy, 1'b1);
    stream(10, REC_N, -1, -1);
    chk("t4_done", done,  1'b1);
    chk("t4_err",  error, 1'b0);
    accept_exp();
    chk_outputs("t4");
    @(negedge clk);

    // Stall for the full timeout: FAIL, outputs kept
    build_rec(8'h10, 8'h66, 8'h77, 8'h88, 8'h01);
    do_start();
    stream(0, 10, -1, -1);
    stall(TO_CYC);
    chk("t4_to_error", error, 1'b1);
    chk("t4_to_busy",  busy,  1'b1);
    chk("t4_to_done",  done,  1'b0);
    @(negedge clk);
    chk("t4_to_idle",  busy,  1'b0);
    chk_outputs("t4_to");

    // Reset in the middle of a load
    build_rec(8'h20, 8'h01, 8'h02, 8'h03, 8'h04);
    do_start();
    stream(0, 20, -1, -1);
    reset_n = 1'b0;
    #1;
    set_reset_exp();
    chk_outputs("t5_rst");
    chk("t5_rst_busy",  busy,       1'b0);
    chk("t5_rst_ready", data_ready, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);

`ifdef INPUT_CONFIG_LOADER_CHECKSUM_EN
    // Correct checksum commits; checksum+1 fails
    build_rec(8'h33, 8'h44, 8'h55, 8'h66, 8'h03);
    do_start();
    stream(0, REC_N, -1, -1);
    chk("t6_done", done, 1'b1);
    accept_exp();
    chk_outputs("t6");
    @(negedge clk);
    build_rec(8'h70, 8'h12, 8'h34, 8'h56, 8'h05);
    rec[REC_N-1] = rec[REC_N-1] + 8'h01;
    do_start();
    stream(0, REC_N, -1, -1);
    chk("t6_bad_err",  error, 1'b1);
    chk("t6_bad_done", done,  1'b0);
    chk_outputs("t6_bad");
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
